// File: rtl/lsu_pkg.sv
// Shared types and constants for the 16-bit load/store unit.
package lsu_pkg;

  // Access sequencing: accept in IDLE, wait on memory in BUSY, report in DONE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  // Little-endian byte enables: bit 0 = low byte, bit 1 = high byte.
  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;

  // Byte-enable pattern for an access of the given size at the given byte offset.
  function automatic logic [1:0] lane_be(input logic is_byte, input logic addr_lsb);
    if (!is_byte) begin
      return BE_WORD;
    end
    return addr_lsb ? BE_HI : BE_LO;
  endfunction

endpackage : lsu_pkg

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the addressed byte lane and extends it to a
// full word, or passes a word load through unchanged.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [15:0] mem_rdata,
  input  logic        addr_lsb,
  input  logic        is_byte,
  input  logic        is_signed,
  output logic [15:0] result
);

  logic [7:0] lane;

  assign lane = addr_lsb ? mem_rdata[15:8] : mem_rdata[7:0];

  // Extend the selected lane (or pass the whole word) to 16 bits.
  always_comb begin
    // NOTE: every branch assigns result; a missing else here would infer a latch.
    if (!is_byte) begin
      result = mem_rdata;
    end else if (is_signed) begin
      result = {{8{lane[7]}}, lane};
    end else begin
      result = {8'h00, lane};
    end
  end

endmodule : lsu_load_align

// File: rtl/lsu_16.sv
// MEM-stage load/store unit: runs a valid/ack handshake with data memory,
// stalls the pipeline while the access is outstanding, aborts after a
// bounded wait and returns aligned, extended load data.
module lsu_16
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic                  req_byte,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_valid,
  output logic                  misalign,
  output logic                  bus_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [1:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  // Wait counter holds 1..TIMEOUT while BUSY; TIMEOUT is limited to 255.
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  lsu_state_e            state_q, state_d;
  logic [7:0]            wait_cnt_q;
  logic                  addr_lsb_q;
  logic                  byte_q;
  logic                  signed_q;
  logic                  accept;
  logic                  complete;
  logic                  timeout;
  logic [DATA_WIDTH-1:0] load_data;

  lsu_load_align u_load_align (
    .mem_rdata (mem_rdata),
    .addr_lsb  (addr_lsb_q),
    .is_byte   (byte_q),
    .is_signed (signed_q),
    .result    (load_data)
  );

  // Next-state logic plus the two combinational outputs (stall, misalign).
  always_comb begin
    // NOTE: defaults first so every path drives every signal.
    state_d  = state_q;
    stall    = 1'b0;
    misalign = 1'b0;
    accept   = 1'b0;
    complete = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (!req_byte && req_addr[0]) begin
            // Word access at an odd address is rejected without touching memory.
            misalign = 1'b1;
          end else begin
            stall   = 1'b1;
            accept  = 1'b1;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (mem_ack) begin
          complete = 1'b1;
          state_d  = DONE;
        end else if (wait_cnt_q == TIMEOUT_CNT) begin
          timeout = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        // The requesting instruction is still in MEM this cycle; req_valid is its own.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register and wait counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        wait_cnt_q <= 8'd1;
      end else if (state_q == BUSY && !mem_ack && !timeout) begin
        wait_cnt_q <= wait_cnt_q + 8'd1;
      end
    end
  end

  // Request capture, memory-side drive and completion reporting.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_be      <= 2'b00;
      mem_wdata   <= '0;
      addr_lsb_q  <= 1'b0;
      byte_q      <= 1'b0;
      signed_q    <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      rdata_valid <= complete;
      bus_err     <= timeout;

      if (accept) begin
        mem_req    <= 1'b1;
        mem_we     <= req_we;
        mem_addr   <= {req_addr[ADDR_WIDTH-1:1], 1'b0};
        mem_be     <= lane_be(req_byte, req_addr[0]);
        mem_wdata  <= req_byte ? {2{req_wdata[7:0]}} : req_wdata;
        addr_lsb_q <= req_addr[0];
        byte_q     <= req_byte;
        signed_q   <= req_signed;
      end else if (complete || timeout) begin
        mem_req <= 1'b0;
      end

      // Stores leave rdata alone; an aborted access of either kind clears it.
      if (complete && !mem_we) begin
        rdata <= load_data;
      end else if (timeout) begin
        rdata <= '0;
      end
    end
  end

endmodule : lsu_16
